gen_rand_range_draw: RTL and testbench

// - Sequential generator of uniform random indices in [0, i_z) for GA selection/crossover/mutation.
// - It is the producing side of the pseudo-modulus reduction, and owns the random source.
// - Draws from an internal Galois LFSR, masks each draw to the bit-width of (i_z-1), and rejects draws >= i_z.
// - After MAX_TRIES rejections it falls back to a pseudo-modulus of the last draw (draw - i_z).

---
 rtl/gen_rand_range_draw.sv | 156 +++++++++++++++
 tb/tb_gen_rand_range_draw.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gen_rand_range_draw.sv
// gen_rand_range_draw: sequential uniform random index generator in [0, z).
// A Galois LFSR supplies draws that are masked to the bit-width of (z-1).
// Draws >= z are rejected and redrawn. After MAX_TRIES draws the last draw is
// folded back into range by a single subtraction (pseudo-modulus fallback).
// Optional macro GEN_RAND_RANGE_STATS_EN adds a saturating rejected-draw
// counter output (o_reject_cnt).
module gen_rand_range_draw #(
    parameter int                DATA_W    = 11,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_z,
    output logic              o_busy,
    output logic              o_res_valid_pls,
    output logic [DATA_W-1:0] o_res,
    output logic              o_fallback
`ifdef GEN_RAND_RANGE_STATS_EN
    ,
    output logic [15:0]       o_reject_cnt
`endif
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [LFSR_W-1:0]   lfsr_reg, lfsr_next, lfsr_stepped;
    logic [TRY_W-1:0]    try_cnt_reg, try_cnt_next;
    logic [DATA_W-1:0]   z_reg, z_next;
    logic [DATA_W-1:0]   res_reg, res_next;
    logic                fb_reg, fb_next;
    logic                pls_reg, pls_next;
    logic [DATA_W-1:0]   z_m1;
    logic [DATA_W-1:0]   mask;
    logic [DATA_W-1:0]   cand;
    logic                z_small;

    // One Galois step of the random source.
    assign lfsr_stepped = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);

    // Mask bit i is set when any bit of (z-1) at or above i is set, which
    // yields ones from bit 0 up to the MSB of (z-1).
    assign z_m1 = z_reg - DATA_W'(1);
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
            assign mask[gi] = |z_m1[DATA_W-1:gi];
        end
    endgenerate

    assign cand    = lfsr_reg[DATA_W-1:0] & mask;
    assign z_small = (z_reg <= DATA_W'(1));

    // Next-state, LFSR advance and registered-output computation.
    always_comb begin
        state_next   = state_reg;
        lfsr_next    = lfsr_reg;
        try_cnt_next = try_cnt_reg;
        z_next       = z_reg;
        res_next     = res_reg;
        fb_next      = fb_reg;
        pls_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_req) begin
                    z_next       = i_z;
                    try_cnt_next = '0;
                    state_next   = DRAW;
                end
            end
            DRAW: begin
                if (z_small) begin
                    // Degenerate range: answer 0 without consuming randomness.
                    res_next   = '0;
                    fb_next    = 1'b0;
                    pls_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    lfsr_next = lfsr_stepped;
                    if (cand < z_reg) begin
                        res_next   = cand;
                        fb_next    = 1'b0;
                        pls_next   = 1'b1;
                        state_next = IDLE;
                    end else if (try_cnt_reg == LAST_TRY) begin
                        // cand < 2*z, so one subtraction lands inside [0, z).
                        res_next   = cand - z_reg;
                        fb_next    = 1'b1;
                        pls_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        try_cnt_next = try_cnt_reg + TRY_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A seed load wins over the step; a draw in flight continues from it.
        if (i_seed_load) begin
            lfsr_next = (i_seed == '0) ? SEED : i_seed;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            lfsr_reg    <= SEED;
            try_cnt_reg <= '0;
            z_reg       <= '0;
            res_reg     <= '0;
            fb_reg      <= 1'b0;
            pls_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lfsr_reg    <= lfsr_next;
            try_cnt_reg <= try_cnt_next;
            z_reg       <= z_next;
            res_reg     <= res_next;
            fb_reg      <= fb_next;
            pls_reg     <= pls_next;
        end
    end

    assign o_busy          = (state_reg != IDLE);
    assign o_res_valid_pls = pls_reg;
    assign o_res           = res_reg;
    assign o_fallback      = fb_reg;

`ifdef GEN_RAND_RANGE_STATS_EN
    logic        reject_draw;
    logic [15:0] rej_cnt_reg;

    assign reject_draw = (state_reg == DRAW) && !z_small && !(cand < z_reg);

    // Saturating count of rejected draws, fallback draws included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rej_cnt_reg <= '0;
        end else if (reject_draw && (rej_cnt_reg != 16'hFFFF)) begin
            rej_cnt_reg <= rej_cnt_reg + 16'd1;
        end
    end

    assign o_reject_cnt = rej_cnt_reg;
`endif

endmodule

// File: tb/tb_gen_rand_range_draw.sv
// Self-checking bench for gen_rand_range_draw: directed table, hand-written
// corner sequences, and random bounds checked against a behavioural model.
module tb_gen_rand_range_draw;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rstn;
    logic        seed_load, seed_load1;
    logic [15:0] seed, seed1;
    logic        req, req1;
    logic [10:0] z, z1;
    logic        busy, pls, fb, busy1, pls1, fb1;
    logic [10:0] res, res1;
`ifdef GEN_RAND_RANGE_STATS_EN
    logic [15:0] rcnt, rcnt1;
`endif

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] m_lfsr;
    int          m_rej;

    always #5 clk = ~clk;

    gen_rand_range_draw dut (
        .clk(clk), .rstn(rstn), .i_seed_load(seed_load), .i_seed(seed),
        .i_req(req), .i_z(z), .o_busy(busy), .o_res_valid_pls(pls),
        .o_res(res), .o_fallback(fb)
`ifdef GEN_RAND_RANGE_STATS_EN
        , .o_reject_cnt(rcnt)
`endif
    );

    gen_rand_range_draw #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .rstn(rstn), .i_seed_load(seed_load1), .i_seed(seed1),
        .i_req(req1), .i_z(z1), .o_busy(busy1), .o_res_valid_pls(pls1),
        .o_res(res1), .o_fallback(fb1)
`ifdef GEN_RAND_RANGE_STATS_EN
        , .o_reject_cnt(rcnt1)
`endif
    );

    typedef struct {
        logic        sl;
        logic [15:0] sd;
        logic [10:0] zz;
        logic [10:0] e_res;
        logic        e_fb;
        int          e_lat;
        logic [15:0] e_lfsr;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    // Rejection sampling over a power-of-two window, then one-subtraction fallback.
    function automatic void model_req(input int max_tries, input int zz,
                                      inout logic [15:0] s, output int r,
                                      output int f, output int lat, output int rej);
        int win;
        int c;
        r = 0; f = 0; lat = 2; rej = 0;
        if (zz <= 1) return;
        win = 1 << $clog2(zz);
        for (int t = 0; t < max_tries; t++) begin
            c = int'(s) % win;
            s = lfsr_step(s);
            lat = 2 + t;
            if (c < zz) begin
                r = c;
                return;
            end
            rej++;
            if (t == max_tries - 1) begin
                r = c - zz;
                f = 1;
            end
        end
    endfunction

    task automatic do_req(input logic [10:0] zz, input logic sl, input logic [15:0] sd,
                          output int r, output int f, output int lat,
                          output int busy_mid, output int busy_end);
        z = zz; req = 1'b1; seed_load = sl; seed = sd;
        @(posedge clk); #1;
        req = 1'b0; seed_load = 1'b0;
        busy_mid = int'(busy);
        lat = 1;
        while (!pls && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = int'(res); f = int'(fb); busy_end = int'(busy);
    endtask

    // Apply one request to the main instance; compare against the model and,
    // when given, against table constants.
    task automatic apply(input logic [10:0] zz, input logic sl, input logic [15:0] sd,
                         input logic use_tbl, input vec_t v);
        int r, f, lat, bm, be, mr, mf, ml, mrej;
        if (sl) m_lfsr = (sd == 16'h0) ? SEED : sd;
        model_req(4, int'(zz), m_lfsr, mr, mf, ml, mrej);
        m_rej += mrej;
        do_req(zz, sl, sd, r, f, lat, bm, be);
        $display("req z=%0d res=%0d fb=%0d lat=%0d lfsr=%04h", zz, r, f, lat, dut.lfsr_reg);
        if (use_tbl) begin
            check("tbl_res", r, int'(v.e_res));
            check("tbl_fb", f, int'(v.e_fb));
            check("tbl_lat", lat, v.e_lat);
            check("tbl_lfsr", int'(dut.lfsr_reg), int'(v.e_lfsr));
        end else begin
            check("rnd_res", r, mr);
            check("rnd_fb", f, mf);
            check("rnd_lat", lat, ml);
            check("rnd_lfsr", int'(dut.lfsr_reg), int'(m_lfsr));
            check("rnd_in_range", int'(r < int'(zz)), 1);
        end
        check("busy_mid", bm, 1);
        check("busy_at_pulse", be, 0);
`ifdef GEN_RAND_RANGE_STATS_EN
        check("reject_cnt", int'(rcnt), m_rej);
`endif
    endtask

    initial begin
        vec_t tbl[7];
        vec_t dummy;
        int   npls;
        tbl[0] = '{1'b1, 16'h0001, 11'd5, 11'd1, 1'b0, 2, 16'hB400};
        tbl[1] = '{1'b0, 16'h0000, 11'd5, 11'd0, 1'b0, 2, 16'h5A00};
        tbl[2] = '{1'b0, 16'h0000, 11'd5, 11'd0, 1'b0, 2, 16'h2D00};
        tbl[3] = '{1'b1, 16'h0007, 11'd5, 11'd3, 1'b0, 3, 16'hEE01};
        tbl[4] = '{1'b0, 16'h0000, 11'd0, 11'd0, 1'b0, 2, 16'hEE01};
        tbl[5] = '{1'b0, 16'h0000, 11'd1, 11'd0, 1'b0, 2, 16'hEE01};
        tbl[6] = '{1'b1, 16'h0000, 11'd2, 11'd1, 1'b0, 2, 16'hE270};
        dummy  = tbl[0];

        rstn = 1'b0;
        seed_load = 1'b0; seed = '0; req = 1'b0; z = '0;
        seed_load1 = 1'b0; seed1 = '0; req1 = 1'b0; z1 = '0;
        m_lfsr = SEED; m_rej = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_pls", int'(pls), 0);
        check("rst_res", int'(res), 0);
        check("rst_fb", int'(fb), 0);
        check("rst_lfsr", int'(dut.lfsr_reg), int'(SEED));
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed table, back-to-back.
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].zz, tbl[i].sl, tbl[i].sd, 1'b1, tbl[i]);
        end

        // Request while busy is ignored: exactly one pulse, LFSR untouched.
        z = 11'd1; req = 1'b1;
        @(posedge clk); #1;
        check("ign_busy", int'(busy), 1);
        z = 11'd5;
        npls = 0;
        @(posedge clk); #1;
        req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (pls) npls++;
            @(posedge clk); #1;
        end
        $display("req z=1 with ignored second request: pulses=%0d", npls);
        check("ign_pulses", npls, 1);
        check("ign_lfsr", int'(dut.lfsr_reg), int'(m_lfsr));

        // Single-try instance: first draw 7 rejected goes straight to fallback.
        begin
            int lat1;
            z1 = 11'd5; req1 = 1'b1; seed_load1 = 1'b1; seed1 = 16'h0007;
            @(posedge clk); #1;
            req1 = 1'b0; seed_load1 = 1'b0;
            lat1 = 1;
            while (!pls1 && lat1 < 20) begin
                @(posedge clk); #1;
                lat1++;
            end
            $display("req(max_tries=1) z=5 res=%0d fb=%0d lat=%0d", res1, fb1, lat1);
            check("mt1_res", int'(res1), 2);
            check("mt1_fb", int'(fb1), 1);
            check("mt1_lat", lat1, 2);
            check("mt1_lfsr", int'(dut1.lfsr_reg), 16'hB403);
`ifdef GEN_RAND_RANGE_STATS_EN
            check("mt1_reject_cnt", int'(rcnt1), 1);
`endif
        end

        // Reset in the middle of a multi-draw request.
        z = 11'd5; req = 1'b1; seed_load = 1'b1; seed = 16'h0007;
        @(posedge clk); #1;
        req = 1'b0; seed_load = 1'b0;
        check("rd_busy_before", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("rd_busy", int'(busy), 0);
        check("rd_res", int'(res), 0);
        check("rd_lfsr", int'(dut.lfsr_reg), int'(SEED));
        @(posedge clk); #1;
        rstn = 1'b1;
        npls = 0;
        for (int c = 0; c < 5; c++) begin
            if (pls) npls++;
            @(posedge clk); #1;
        end
        $display("reset mid-draw: pulses afterwards=%0d", npls);
        check("rd_no_pulse", npls, 0);
        m_lfsr = SEED; m_rej = 0;

        // Random bounds, with an occasional seed reload (seed 0 included).
        for (int i = 0; i < 10000; i++) begin
            logic [10:0] zz;
            logic        sl;
            logic [15:0] sd;
            zz = 11'($urandom_range(2047, 2));
            sl = ($urandom_range(63, 0) == 0);
            sd = ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom);
            apply(zz, sl, sd, 1'b0, dummy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
